// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing pipeline: default pixel width,
// 3x3 window geometry and named tap positions inside a flattened window.
package img_proc_pkg;

  localparam int PIX_W_DEF = 8;   // grey pixel width used by the pipeline
  localparam int WIN_ROWS  = 3;
  localparam int WIN_COLS  = 3;
  localparam int NUM_TAPS  = WIN_ROWS * WIN_COLS;

  // Tap k = 3*r + c, r=0 is the oldest (top) line, c=0 the leftmost column.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;   // newest pixel

  // Flattened tap index for window row r, column c.
  function automatic int tap_idx(input int r, input int c);
    return WIN_COLS * r + c;
  endfunction

endpackage

// File: rtl/line_delay.sv
// Enable-gated delay of DEPTH accepted samples, built as a circular buffer.
// dout presents the sample written DEPTH enables ago; it is overwritten by
// din on the next enabled edge.
module line_delay #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;

  // Oldest sample sits where the next write will land.
  assign dout = mem[ptr];

  // Advance the circular pointer once per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

  // Store the incoming sample in the slot just read out.
  // NOTE: the storage array has no reset so it maps onto RAM; nothing downstream
  // trusts its contents until two full lines have been written since (0,0).
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator. Two line delays supply the pixels one and
// two lines above the incoming pixel; a 3x3 shift register collects the last
// three columns and a registered window is emitted one cycle after every
// pixel whose window lies fully inside the frame.
module line_buffer_3x3
  import img_proc_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_valid,
  input  logic [PIX_W-1:0]            pix_in,
  input  logic                        sof,
  output logic                        win_valid,
  output logic [NUM_TAPS*PIX_W-1:0]   win,
  output logic [$clog2(IMG_W)-1:0]    win_cx,
  output logic [$clog2(IMG_H)-1:0]    win_cy,
  output logic                        frame_done
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          emit;
  logic          last_pix;

  logic [PIX_W-1:0] line1;   // pixel at (x, y-1)
  logic [PIX_W-1:0] line2;   // pixel at (x, y-2)

  logic [NUM_TAPS-1:0][PIX_W-1:0] sr_q;
  logic [NUM_TAPS-1:0][PIX_W-1:0] sr_d;

  line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_delay_y1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_valid),
    .din   (pix_in),
    .dout  (line1)
  );

  line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_delay_y2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_valid),
    .din   (line1),
    .dout  (line2)
  );

  // Coordinates of the pixel on the input this cycle; sof forces the origin.
  always_comb begin
    cur_x    = sof ? '0 : col;
    cur_y    = sof ? '0 : row;
    emit     = pix_valid && (cur_x >= XW'(2)) && (cur_y >= YW'(2));
    last_pix = (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));
  end

  // Next window contents: shift one column left, new column enters on the right.
  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    sr_d = sr_q;
    for (int r = 0; r < WIN_ROWS; r++) begin
      sr_d[tap_idx(r, 0)] = sr_q[tap_idx(r, 1)];
      sr_d[tap_idx(r, 1)] = sr_q[tap_idx(r, 2)];
    end
    sr_d[TAP_TR] = line2;
    sr_d[TAP_MR] = line1;
    sr_d[TAP_BR] = pix_in;
  end

  // Raster counters and window shift register advance on accepted pixels only.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      sr_q <= '0;
    end else if (pix_valid) begin
      sr_q <= sr_d;
      if (cur_x == XW'(IMG_W - 1)) begin
        col <= '0;
        row <= (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
      end else begin
        col <= cur_x + XW'(1);
        row <= cur_y;
      end
    end
  end

  // Registered window outputs; data and coordinates hold between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win        <= '0;
      win_cx     <= '0;
      win_cy     <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= emit && last_pix;
      if (emit) begin
        win    <= sr_d;
        win_cx <= cur_x - XW'(1);
        win_cy <= cur_y - YW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3x3.sv
// Self-checking bench for line_buffer_3x3 on a 4x4 frame, pixel = 4y+x+1.
// The reference keeps the frame as a plain 2-D image and cuts each expected
// window straight out of it; a compare process checks every cycle.
module tb_line_buffer_3x3;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WB = 9 * PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_valid;
  logic [PW-1:0] pix_in;
  logic          sof;
  logic          win_valid;
  logic [WB-1:0] win;
  logic [1:0]    win_cx;
  logic [1:0]    win_cy;
  logic          frame_done;

  line_buffer_3x3 #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .sof        (sof),
    .win_valid  (win_valid),
    .win        (win),
    .win_cx     (win_cx),
    .win_cy     (win_cy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  int            img [H][W];
  int            mx = 0;
  int            my = 0;
  logic          exp_valid = 1'b0;
  logic          exp_fd    = 1'b0;
  logic [WB-1:0] exp_win   = '0;
  logic [1:0]    exp_cx    = '0;
  logic [1:0]    exp_cy    = '0;

  // Windows captured from the DUT for literal pinning
  logic [WB-1:0] cap_win [$];
  logic [1:0]    cap_cx  [$];
  logic [1:0]    cap_cy  [$];
  logic          cap_fd  [$];

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WB-1:0] pack9(input int t0, input int t1, input int t2,
                                          input int t3, input int t4, input int t5,
                                          input int t6, input int t7, input int t8);
    logic [WB-1:0] v;
    v = {PW'(t8), PW'(t7), PW'(t6), PW'(t5), PW'(t4), PW'(t3), PW'(t2), PW'(t1), PW'(t0)};
    return v;
  endfunction

  function automatic logic [WB-1:0] win_at(input int k);
    return (cap_win.size() > k) ? cap_win[k] : '0;
  endfunction

  function automatic logic [1:0] cx_at(input int k);
    return (cap_cx.size() > k) ? cap_cx[k] : 2'd0;
  endfunction

  function automatic logic [1:0] cy_at(input int k);
    return (cap_cy.size() > k) ? cap_cy[k] : 2'd0;
  endfunction

  function automatic logic fd_at(input int k);
    return (cap_fd.size() > k) ? cap_fd[k] : 1'b0;
  endfunction

  function automatic int fd_count();
    int n = 0;
    foreach (cap_fd[i]) n += int'(cap_fd[i]);
    return n;
  endfunction

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    check("win_valid",  WB'(win_valid),  WB'(exp_valid));
    check("frame_done", WB'(frame_done), WB'(exp_fd));
    check("win",        win,             exp_win);
    check("win_cx",     WB'(win_cx),     WB'(exp_cx));
    check("win_cy",     WB'(win_cy),     WB'(exp_cy));
    if (win_valid) begin
      cap_win.push_back(win);
      cap_cx.push_back(win_cx);
      cap_cy.push_back(win_cy);
      cap_fd.push_back(frame_done);
    end
  end

  // Drive one cycle and predict the outputs that follow its rising edge.
  task automatic apply(input logic v, input logic s, input int p);
    @(negedge clk);
    #1;
    pix_valid = v;
    sof       = s;
    pix_in    = PW'(p);
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (v) begin
      if (s) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = p;
      if (mx >= 2 && my >= 2) begin
        exp_valid = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_win[(3*r+c)*PW +: PW] = PW'(img[my-2+r][mx-2+c]);
        exp_cx = 2'(mx - 1);
        exp_cy = 2'(my - 1);
        exp_fd = (mx == W-1) && (my == H-1);
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    exp_valid = 1'b0; exp_fd = 1'b0; exp_win = '0; exp_cx = '0; exp_cy = '0;
    mx = 0; my = 0;
    #1;
    check("rst_async_valid", WB'(win_valid), '0);
    check("rst_async_win",   win,            '0);
    check("rst_async_cx_cy", WB'({win_cx, win_cy}), '0);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input bit gaps, input bit with_sof);
    for (int i = 0; i < W*H; i++) begin
      apply(1'b1, with_sof && (i == 0), i + 1);
      if (gaps) apply(1'b0, 1'b0, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 0);
  endtask

  task automatic clear_caps();
    cap_win.delete(); cap_cx.delete(); cap_cy.delete(); cap_fd.delete();
  endtask

  initial begin
    logic [WB-1:0] first_w;
    logic [WB-1:0] last_w;
    first_w = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    last_w  = pack9(6, 7, 8, 10, 11, 12, 14, 15, 16);

    rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
    foreach (img[y, x]) img[y][x] = 0;
    do_reset(3);
    idle(1);
    check("reset_valid", WB'(win_valid), '0);
    check("reset_win",   win,            '0);

    // Back-to-back frame
    clear_caps();
    run_frame(1'b0, 1'b1);
    idle(2);
    check("f1_count",    WB'(cap_win.size()), WB'(4));
    check("f1_first",    win_at(0), first_w);
    check("f1_first_cx", WB'(cx_at(0)), WB'(1));
    check("f1_first_cy", WB'(cy_at(0)), WB'(1));
    check("f1_first_fd", WB'(fd_at(0)), '0);
    check("f1_last",     win_at(3), last_w);
    check("f1_last_cx",  WB'(cx_at(3)), WB'(2));
    check("f1_last_cy",  WB'(cy_at(3)), WB'(2));
    check("f1_last_fd",  WB'(fd_at(3)), WB'(1));
    check("f1_fd_count", WB'(fd_count()), WB'(1));

    // Same frame with a bubble after every pixel
    clear_caps();
    run_frame(1'b1, 1'b1);
    idle(2);
    check("gap_count", WB'(cap_win.size()), WB'(4));
    check("gap_first", win_at(0), first_w);
    check("gap_last",  win_at(3), last_w);

    // Two frames back to back
    clear_caps();
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b1);
    idle(2);
    check("two_count",  WB'(cap_win.size()), WB'(8));
    check("two_second", win_at(4), first_w);
    check("two_fd",     WB'(fd_count()), WB'(2));

    // Frame aborted by sof on the 7th pixel
    clear_caps();
    for (int i = 0; i < 6; i++) apply(1'b1, i == 0, i + 1);
    run_frame(1'b0, 1'b1);
    idle(2);
    check("sof_count",    WB'(cap_win.size()), WB'(4));
    check("sof_first",    win_at(0), first_w);
    check("sof_first_cx", WB'(cx_at(0)), WB'(1));
    check("sof_first_cy", WB'(cy_at(0)), WB'(1));

    // Reset after pixel 10, then a full frame without sof
    clear_caps();
    for (int i = 0; i < 10; i++) apply(1'b1, i == 0, i + 1);
    do_reset(3);
    run_frame(1'b0, 1'b0);
    idle(2);
    check("rst_count", WB'(cap_win.size()), WB'(4));
    check("rst_first", win_at(0), first_w);
    check("rst_last",  win_at(3), last_w);
    check("rst_fd",    WB'(fd_at(3)), WB'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
